// File: rtl/phys_reg_manager_if.sv
// Rename-side bundle for the physical register manager: allocation, commit,
// writeback, source-ready query, flush and status.
interface phys_reg_manager_if #(
  parameter int TAG_W = 6,
  parameter int CNT_W = 6
);
  logic             alloc_req;
  logic             alloc_gnt;
  logic [TAG_W-1:0] alloc_tag;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_old_tag;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [TAG_W-1:0] query_tag_a;
  logic [TAG_W-1:0] query_tag_b;
  logic             query_rdy_a;
  logic             query_rdy_b;
  logic             flush;
  logic [CNT_W-1:0] free_count;
  logic             hazard;
  logic             protocol_err;

  modport master (
    output alloc_req, commit_valid, commit_old_tag, wb_valid, wb_tag,
           query_tag_a, query_tag_b, flush,
    input  alloc_gnt, alloc_tag, query_rdy_a, query_rdy_b, free_count,
           hazard, protocol_err
  );

  modport slave (
    input  alloc_req, commit_valid, commit_old_tag, wb_valid, wb_tag,
           query_tag_a, query_tag_b, flush,
    output alloc_gnt, alloc_tag, query_rdy_a, query_rdy_b, free_count,
           hazard, protocol_err
  );
endinterface

// File: rtl/phys_reg_manager.sv
// Physical register free list (speculative head, commit head, tail) plus ready scoreboard.
// Grant, tag and query outputs are combinational; all state updates on the next rising clk.
module phys_reg_manager #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int FL_DEPTH  = 32
) (
  input logic               clk,
  input logic               rst_n,
  phys_reg_manager_if.slave bus
);
  localparam int TAG_W = $clog2(NUM_PREGS);
  localparam int IDX_W = $clog2(FL_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;

  tag_t                 fifo_q [FL_DEPTH];
  ptr_t                 spec_head_q, commit_head_q, tail_q;
  ptr_t                 spec_head_d, commit_head_d, tail_d;
  logic [NUM_PREGS-1:0] ready_q, ready_d;
  logic                 protocol_err_q, protocol_err_d;

  tag_t head_tag;
  ptr_t free_cnt;
  logic gnt;
  logic commit_ok;
  logic commit_bad;
  ptr_t in_list;

  assign head_tag   = fifo_q[spec_head_q[IDX_W-1:0]];
  // Pointer difference with the wrap bit distinguishes 0 from FL_DEPTH.
  assign free_cnt   = tail_q - spec_head_q;
  assign gnt        = bus.alloc_req & (free_cnt != '0) & ~bus.flush;
  assign commit_ok  = bus.commit_valid & (commit_head_q != spec_head_q);
  assign commit_bad = bus.commit_valid & (commit_head_q == spec_head_q);

  always_comb begin
    commit_head_d  = commit_head_q;
    tail_d         = tail_q;
    spec_head_d    = spec_head_q;
    ready_d        = ready_q;
    protocol_err_d = protocol_err_q | commit_bad;

    if (commit_ok) begin
      commit_head_d = commit_head_q + ptr_t'(1);
      tail_d        = tail_q + ptr_t'(1);
    end

    // Rollback lands on the commit head including this cycle's retirement.
    if (bus.flush)
      spec_head_d = commit_head_d;
    else if (gnt)
      spec_head_d = spec_head_q + ptr_t'(1);

    if (bus.wb_valid && (bus.wb_tag != '0))
      ready_d[bus.wb_tag] = 1'b1;
    // Applied after writeback so a same-edge allocation of the tag wins.
    if (gnt && (head_tag != '0))
      ready_d[head_tag] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++)
        fifo_q[i] <= tag_t'(NUM_AREGS + i);
      spec_head_q    <= '0;
      commit_head_q  <= '0;
      tail_q         <= ptr_t'(FL_DEPTH);
      ready_q        <= '1;
      protocol_err_q <= 1'b0;
    end else begin
      if (commit_ok)
        fifo_q[tail_q[IDX_W-1:0]] <= bus.commit_old_tag;
      spec_head_q    <= spec_head_d;
      commit_head_q  <= commit_head_d;
      tail_q         <= tail_d;
      ready_q        <= ready_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign bus.alloc_gnt    = gnt;
  assign bus.alloc_tag    = head_tag;
  assign bus.free_count   = free_cnt;
  assign bus.hazard       = (free_cnt == '0);
  assign bus.protocol_err = protocol_err_q;

  // Tag 0 is the hardwired-ready register; writeback bypasses the table.
  assign bus.query_rdy_a = ready_q[bus.query_tag_a] | (bus.query_tag_a == '0) |
                           (bus.wb_valid & (bus.wb_tag == bus.query_tag_a) & (bus.wb_tag != '0));
  assign bus.query_rdy_b = ready_q[bus.query_tag_b] | (bus.query_tag_b == '0) |
                           (bus.wb_valid & (bus.wb_tag == bus.query_tag_b) & (bus.wb_tag != '0));

  assign in_list = tail_q - commit_head_q;

  a_committed_list_full: assert property (
    @(posedge clk) disable iff (!rst_n) in_list == ptr_t'(FL_DEPTH)
  );
endmodule

// File: tb/tb_phys_reg_manager.sv
// Directed, table-driven bench for phys_reg_manager with hand-computed expectations.
module tb_phys_reg_manager;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phys_reg_manager_if bus ();

  phys_reg_manager dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       req;
    logic       cv;
    logic [5:0] cot;
    logic       wv;
    logic [5:0] wt;
    logic [5:0] qa;
    logic [5:0] qb;
    logic       fl;
    logic       gnt;
    logic [5:0] tag;
    logic [5:0] fc;
    logic       hz;
    logic       ra;
    logic       rb;
    logic       perr;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  vec_t tbl1[$];
  vec_t tbl2[$];
  vec_t rst_exp;

  function automatic vec_t mk(string nm, int req, int cv, int cot, int wv, int wt,
                              int qa, int qb, int fl, int gnt, int tag, int fc,
                              int hz, int ra, int rb, int perr);
    vec_t v;
    v.name = nm;
    v.req  = 1'(req);
    v.cv   = 1'(cv);
    v.cot  = 6'(cot);
    v.wv   = 1'(wv);
    v.wt   = 6'(wt);
    v.qa   = 6'(qa);
    v.qb   = 6'(qb);
    v.fl   = 1'(fl);
    v.gnt  = 1'(gnt);
    v.tag  = 6'(tag);
    v.fc   = 6'(fc);
    v.hz   = 1'(hz);
    v.ra   = 1'(ra);
    v.rb   = 1'(rb);
    v.perr = 1'(perr);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.alloc_req      = v.req;
    bus.commit_valid   = v.cv;
    bus.commit_old_tag = v.cot;
    bus.wb_valid       = v.wv;
    bus.wb_tag         = v.wt;
    bus.query_tag_a    = v.qa;
    bus.query_tag_b    = v.qb;
    bus.flush          = v.fl;
  endtask

  task automatic check(input vec_t v);
    n_chk++;
    if (bus.alloc_gnt === v.gnt && bus.alloc_tag === v.tag && bus.free_count === v.fc &&
        bus.hazard === v.hz && bus.query_rdy_a === v.ra && bus.query_rdy_b === v.rb &&
        bus.protocol_err === v.perr)
      n_pass++;
    else
      $display("FAIL %s: got gnt=%0b tag=%0d fc=%0d hz=%0b ra=%0b rb=%0b perr=%0b, want gnt=%0b tag=%0d fc=%0d hz=%0b ra=%0b rb=%0b perr=%0b",
               v.name, bus.alloc_gnt, bus.alloc_tag, bus.free_count, bus.hazard,
               bus.query_rdy_a, bus.query_rdy_b, bus.protocol_err,
               v.gnt, v.tag, v.fc, v.hz, v.ra, v.rb, v.perr);
  endtask

  // Entered 1 time unit after a rising edge; samples mid-cycle, then advances one cycle.
  task automatic step(input vec_t v);
    drive(v);
    #3;
    check(v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(rst_exp);
    #3;
    check(rst_exp);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_exp = mk("reset", 0,0,0,0,0, 32,0,0, 0,32,32,0,1,1,0);

    tbl1.push_back(mk("bad_commit",  0,1,9,0,0,  32,0,0,  0,32,32,0,1,1,0));
    tbl1.push_back(mk("err_sticky",  0,0,0,0,0,  32,0,0,  0,32,32,0,1,1,1));
    tbl1.push_back(mk("alloc32",     1,0,0,0,0,  32,0,0,  1,32,32,0,1,1,1));
    tbl1.push_back(mk("q32_busy",    0,0,0,0,0,  32,33,0, 0,33,31,0,0,1,1));
    tbl1.push_back(mk("wb32_bypass", 0,0,0,1,32, 32,33,0, 0,33,31,0,1,1,1));
    tbl1.push_back(mk("q32_stays",   0,0,0,0,0,  32,0,0,  0,33,31,0,1,1,1));
    tbl1.push_back(mk("alloc33",     1,0,0,0,0,  33,32,0, 1,33,31,0,1,1,1));
    tbl1.push_back(mk("alloc34",     1,0,0,0,0,  34,33,0, 1,34,30,0,1,0,1));
    tbl1.push_back(mk("commit5",     0,1,5,0,0,  34,0,0,  0,35,29,0,0,1,1));
    tbl1.push_back(mk("flush",       0,0,0,0,0,  0,0,1,   0,35,30,0,1,1,1));
    tbl1.push_back(mk("after_flush", 0,0,0,0,0,  33,34,0, 0,33,32,0,0,0,1));

    tbl2.push_back(mk("alloc33_b",   1,0,0,0,0,  0,0,0,   1,33,31,0,1,1,0));
    tbl2.push_back(mk("alloc_cmt_fl",1,1,7,0,0,  0,0,1,   0,34,30,0,1,1,0));
    tbl2.push_back(mk("post_acf",    0,0,0,0,0,  33,7,0,  0,33,32,0,0,1,0));
    for (int k = 0; k < 7; k++)
      tbl2.push_back(mk("walk_to_40", 1,0,0,0,0, 0,0,0, 1,33+k,32-k,0,1,1,0));
    tbl2.push_back(mk("alloc_wb40",  1,0,0,1,40, 40,0,0,  1,40,25,0,1,1,0));
    tbl2.push_back(mk("r40_cleared", 0,0,0,0,0,  40,41,0, 0,41,24,0,0,1,0));

    @(posedge clk);
    #1;
    do_reset();

    // Drain the whole free list, then one more request hits the hazard.
    for (int i = 0; i <= 32; i++)
      step(mk("drain", 1,0,0,0,0,
              (i < 32) ? 32 + i : 32, (i == 0) ? 0 : ((i < 32) ? 31 + i : 63), 0,
              (i < 32) ? 1 : 0, (i < 32) ? 32 + i : 32, 32 - i,
              (i == 32) ? 1 : 0, (i < 32) ? 1 : 0, (i == 0) ? 1 : 0, 0));

    do_reset();
    foreach (tbl1[i]) step(tbl1[i]);

    // Allocate through the wrap until the freed tag 5 comes out of index 0.
    for (int i = 0; i < 32; i++)
      step(mk("wrap", 1,0,0,0,0, 0,0,0, 1, (i < 31) ? 33 + i : 5, 32 - i, 0,1,1,1));

    step(mk("free_same_cycle", 1,1,12,0,0, 0,0,0, 0,33,0,1,1,1,1));
    step(mk("grant_freed",     1,0,0,0,0,  0,0,0, 1,12,1,0,1,1,1));
    step(mk("empty_again",     0,0,0,0,0,  12,0,0, 0,34,0,1,0,1,1));

    // Asynchronous reset in mid-cycle while allocations are outstanding.
    drive(mk("mid", 0,0,0,0,0, 32,0,0, 0,0,0,0,0,0,0));
    #2;
    rst_n = 1'b0;
    #1;
    check(mk("mid_reset", 0,0,0,0,0, 32,0,0, 0,32,32,0,1,1,0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(mk("first_gnt", 1,0,0,0,0, 32,12,0, 1,32,32,0,1,1,0));

    foreach (tbl2[i]) step(tbl2[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
